tag_event_fifo: RTL and testbench

- Buffers the 32-bit time-tag words emitted by the pulse-registration stage (one-cycle `ready` strobe plus `data`) so that a slower host or USB readout can drain them.
- Absorbs bursts at full clock rate.
- Exposes a first-word-fall-through read interface with a valid/read handshake.
- Accounts for every word lost to overflow.

---
 rtl/tagger_pkg.sv | 15 +
 rtl/tag_fifo_ram.sv | 35 +++
 rtl/tag_event_fifo.sv | 117 +++++++++++
 tb/tb_tag_event_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tagger_pkg.sv
// Word-field layout shared by the pulse tagger, the tag event FIFO and host decode.
package tagger_pkg;

  localparam int WORD_W   = 32;
  localparam int TS_MSB   = 26;
  localparam int CH_LSB   = 27;
  localparam int CH_MSB   = 30;
  localparam int ROLL_BIT = 31;

  // Rollover marker of a tag word; the FIFO itself never interprets it.
  function automatic logic is_rollover(input logic [WORD_W-1:0] word);
    return word[ROLL_BIT];
  endfunction

endpackage

// File: rtl/tag_fifo_ram.sv
// Simple dual-port word RAM with a registered read port. The read register
// doubles as the FIFO output register, so it carries a synchronous reset
// while the storage array stays uninitialised.
module tag_fifo_ram
  import tagger_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [(1<<ADDR_W)];
  logic [WORD_W-1:0] rdata_q;

  // Write port: one word per cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: registered, updated only when a fetch is requested.
  always_ff @(posedge clk) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tag_event_fifo.sv
// Time-tag buffer between the tagger and a slower readout. First-word-fall-
// through: the RAM read register holds the head word, and a new head is
// fetched in the same edge as a pop so back-to-back reads run at full rate.
// Handshake: a word is written when ready=1 and there is room (or a pop
// happens in the same cycle); the head is popped at an edge where
// out_read=1 and out_valid=1. Words arriving while full are counted as drops.
module tag_event_fifo
  import tagger_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int AFULL_LEVEL = 1008,
  parameter int DROP_W      = 16
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  ready,
  input  logic [WORD_W-1:0]     data,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_read,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count,
  input  logic                  ack_overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_LVL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0]   DROP_ONE  = {{(DROP_W-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DEPTH_LOG2:0]   ram_cnt;
  logic                  out_valid_q, out_valid_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_W-1:0]     drop_count_q, drop_count_d;
  logic                  pop, full, wr_acc, drop, fetch;

  // Next-state for pointers, occupancy, head-valid and drop accounting.
  always_comb begin
    pop     = out_read && out_valid_q;
    full    = (level_q == FULL_LVL);
    wr_acc  = ready && (!full || pop);
    drop    = ready && full && !pop;
    // Words in RAM not yet moved into the read register.
    ram_cnt = level_q - {{DEPTH_LOG2{1'b0}}, out_valid_q};
    fetch   = (ram_cnt != '0) && (!out_valid_q || pop);

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = fetch  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    if (wr_acc && !pop)      level_d = level_q + LVL_ONE;
    else if (!wr_acc && pop) level_d = level_q - LVL_ONE;

    out_valid_d = out_valid_q;
    if (fetch)    out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;

    almost_full_d = int'(level_d) >= AFULL_LEVEL;

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ack_overflow)            drop_count_d = DROP_ONE;
      else if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_ONE;
    end else if (ack_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // State registers; clear flushes everything and ignores a same-cycle strobe.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  tag_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst_i   (clear),
    .we_i    (wr_acc && !clear),
    .waddr_i (wr_ptr_q),
    .wdata_i (data),
    .re_i    (fetch && !clear),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  assign out_valid   = out_valid_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_tag_event_fifo.sv
// Bench for tag_event_fifo: small configuration (16 words, almost_full at 12,
// 3-bit drop counter). Expected words go into exp_q as they are written;
// a monitor pops and compares every word the DUT hands out.
module tb_tag_event_fifo;

  localparam int DL2 = 4;
  localparam int DW  = 3;

  logic            clk = 1'b0;
  logic            clear, ready, out_read, ack_overflow;
  logic [31:0]     data, out_data;
  logic            out_valid, almost_full, overflow;
  logic [DL2:0]    level;
  logic [DW-1:0]   drop_count;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int gaps   = 0;
  int budget = 0;

  tag_event_fifo #(
    .DEPTH_LOG2  (DL2),
    .AFULL_LEVEL (12),
    .DROP_W      (DW)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .ready        (ready),
    .data         (data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_read     (out_read),
    .level        (level),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .ack_overflow (ack_overflow)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop must match the oldest expected word.
  always @(negedge clk) begin
    if (out_valid && out_read) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected none", out_data);
      end else begin
        chk("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit acc);
    ready = 1'b1;
    data  = d;
    if (acc) exp_q.push_back(d);
    step();
    ready = 1'b0;
  endtask

  task automatic pop_one();
    out_read = 1'b1;
    step();
    out_read = 1'b0;
  endtask

  task automatic drain(input string name);
    out_read = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      step();
      budget++;
    end
    out_read = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    clear = 1'b1; ready = 1'b0; data = '0; out_read = 1'b0; ack_overflow = 1'b0;
    step();
    step();
    clear = 1'b0;

    // Reset state
    chk("rst_out_valid",  32'(out_valid),   32'd0);
    chk("rst_out_data",   out_data,         32'd0);
    chk("rst_level",      32'(level),       32'd0);
    chk("rst_afull",      32'(almost_full), 32'd0);
    chk("rst_overflow",   32'(overflow),    32'd0);
    chk("rst_drop_count", 32'(drop_count),  32'd0);

    // Single word: visible two edges after the strobe is presented
    wr(32'h0800_0005, 1'b1);
    chk("single_not_yet_valid", 32'(out_valid), 32'd0);
    chk("single_level_early",   32'(level),     32'd1);
    step();
    chk("single_valid",    32'(out_valid), 32'd1);
    chk("single_data",     out_data,       32'h0800_0005);
    chk("single_level",    32'(level),     32'd1);
    pop_one();
    chk("single_pop_valid", 32'(out_valid), 32'd0);
    chk("single_pop_level", 32'(level),     32'd0);

    // Read while empty is ignored
    pop_one();
    chk("empty_read_level", 32'(level),     32'd0);
    chk("empty_read_valid", 32'(out_valid), 32'd0);

    // Burst of 300 with reads held high: no gaps after the first word
    out_read = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ready = 1'b1;
      data  = 32'(i);
      exp_q.push_back(32'(i));
      if (i >= 2) begin
        @(negedge clk);
        if (!out_valid) gaps++;
      end
      step();
    end
    ready = 1'b0;
    drain("burst_drained");
    chk("burst_gaps",  32'(gaps),  32'd0);
    step();
    chk("burst_level", 32'(level), 32'd0);

    // Full and overflow: 20 strobes into 16 words
    for (int i = 0; i < 20; i++) wr(32'h1000_0000 + 32'(i), i < 16);
    chk("full_level",    32'(level),       32'd16);
    chk("full_afull",    32'(almost_full), 32'd1);
    chk("full_overflow", 32'(overflow),    32'd1);
    chk("full_drops",    32'(drop_count),  32'd4);

    // Strobe plus pop while full: accepted, no drop
    out_read = 1'b1;
    ready    = 1'b1;
    data     = 32'h2000_0000;
    exp_q.push_back(32'h2000_0000);
    step();
    out_read = 1'b0;
    ready    = 1'b0;
    chk("full_pop_wr_level", 32'(level),      32'd16);
    chk("full_pop_wr_drops", 32'(drop_count), 32'd4);

    drain("full_drained");
    step();
    chk("full_drain_level",  32'(level),       32'd0);
    chk("full_drain_afull",  32'(almost_full), 32'd0);
    chk("overflow_sticky",   32'(overflow),    32'd1);
    ack_overflow = 1'b1;
    step();
    ack_overflow = 1'b0;
    chk("ack1_overflow", 32'(overflow),   32'd0);
    chk("ack1_drops",    32'(drop_count), 32'd0);

    // Saturation: 10 drops into a 3-bit counter
    for (int i = 0; i < 26; i++) wr(32'h3000_0000 + 32'(i), i < 16);
    chk("sat_drops",    32'(drop_count), 32'd7);
    chk("sat_overflow", 32'(overflow),   32'd1);
    ack_overflow = 1'b1;
    step();
    ack_overflow = 1'b0;
    chk("ack2_overflow", 32'(overflow),   32'd0);
    chk("ack2_drops",    32'(drop_count), 32'd0);
    // Ack coinciding with a drop: drop wins
    ack_overflow = 1'b1;
    wr(32'h3fff_ffff, 1'b0);
    ack_overflow = 1'b0;
    chk("ackdrop_overflow", 32'(overflow),   32'd1);
    chk("ackdrop_drops",    32'(drop_count), 32'd1);

    // Clear mid-operation
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) wr(32'h4000_0000 + 32'(i), 1'b1);
    step();
    chk("pre_clear_level", 32'(level), 32'd5);
    clear = 1'b1;
    ready = 1'b1;
    data  = 32'hdead_beef;
    step();
    clear = 1'b0;
    ready = 1'b0;
    exp_q.delete();
    chk("clear_level",    32'(level),       32'd0);
    chk("clear_valid",    32'(out_valid),   32'd0);
    chk("clear_out_data", out_data,         32'd0);
    chk("clear_drops",    32'(drop_count),  32'd0);
    chk("clear_overflow", 32'(overflow),    32'd0);
    chk("clear_afull",    32'(almost_full), 32'd0);

    // Rollover word after clear
    wr(32'h8000_0000, 1'b1);
    step();
    chk("roll_valid", 32'(out_valid), 32'd1);
    pop_one();
    chk("roll_level", 32'(level), 32'd0);

    step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
